// File: rtl/dp_ram_port_ctrl.sv
// Single-port initiator for one side of a dual-port RAM: fills the RAM with INIT_VALUE after
// reset or clr, then forwards valid/ready read/write requests and buffers read data (2 deep).
module dp_ram_port_ctrl #(
  parameter int unsigned          DATA_WIDTH = 2,
  parameter int unsigned          ADDR_WIDTH = 2,
  parameter int unsigned          RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  ram_we_n,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
  logic                    rd_pend_q;
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              cnt_q;
  logic [1:0]              occ;
  logic                    accept, push, pop;

  // Occupancy counts the in-flight read so the buffer can never overflow.
  assign occ       = cnt_q + {1'b0, rd_pend_q};
  assign req_ready = !rst && (state_q == StRun) && !clr && (occ < 2'd2);
  assign accept    = req_valid && req_ready;
  assign push      = rd_pend_q;
  assign rsp_valid = !rst && (cnt_q != 2'd0);
  assign rsp_rdata = rst ? '0 : buf_q[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    init_done  = 1'b0;
    ram_we_n   = 1'b1;
    ram_addr   = '0;
    ram_din    = '0;
    unique case (state_q)
      StInit: begin
        ram_we_n = 1'b0;
        ram_addr = fill_cnt_q;
        ram_din  = INIT_VALUE;
        if (fill_cnt_q == LastAddr) begin
          fill_cnt_d = '0;
          state_d    = StRun;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      StRun: begin
        init_done = 1'b1;
        if (clr) begin
          state_d = StInit;
        end else if (accept) begin
          ram_addr = req_addr;
          ram_we_n = !req_write;
          ram_din  = req_write ? req_wdata : '0;
        end
      end
    endcase
    if (rst) begin
      init_done = 1'b0;
      ram_we_n  = 1'b1;
      ram_addr  = '0;
      ram_din   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      fill_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_pend_q  <= accept && !req_write;
      // Capture is independent of FSM state so a read issued just before clr completes.
      if (push) begin
        buf_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_ram_port_ctrl.sv
// Bench for dp_ram_port_ctrl: behavioural RAM plus a transaction-level reference model
// (memory image and queue of expected read responses) checked every cycle.
module tb_dp_ram_port_ctrl;

  localparam int unsigned DW    = 2;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [DW-1:0] INIT = 2'b10;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          ram_we_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  dp_ram_port_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RAM_DEPTH (DEPTH),
    .INIT_VALUE(INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_we_n (ram_we_n),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Registered-output RAM port
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (!ram_we_n) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model
  bit            run_m;
  int            fill_m;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_data[$];
  int            exp_cyc[$];
  int            total = 0;
  int            bad   = 0;
  bit            acc_b;

  task automatic set_idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clr       = 1'b0;
  endtask

  task automatic set_req(input bit wr, input int a, input int d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = AW'(a);
    req_wdata = DW'(d);
  endtask

  // Checks one cycle against the model, clocks it, then advances the model.
  task automatic drive_cycle(output bit acc);
    bit            ev, er, pop, wr;
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d, wd;
    acc = 1'b0;
    #1;
    if (rst) begin
      total++;
      if ({req_ready, rsp_valid, init_done, ram_we_n} !== 4'b0001) begin
        bad++;
        $display("FAIL rst_ctrl got=%b want=0001", {req_ready, rsp_valid, init_done, ram_we_n});
      end
      total++;
      if ({ram_addr, ram_din, rsp_rdata} !== '0) begin
        bad++;
        $display("FAIL rst_data got addr=%0d din=%0d rdata=%0d want all 0",
                 ram_addr, ram_din, rsp_rdata);
      end
      @(posedge clk);
      #1;
      run_m  = 1'b0;
      fill_m = 0;
      exp_data.delete();
      exp_cyc.delete();
      return;
    end
    total++;
    if (init_done !== run_m) begin
      bad++;
      $display("FAIL init_done got=%b want=%b", init_done, run_m);
    end
    er = run_m && !clr && (exp_data.size() < 2);
    total++;
    if (req_ready !== er) begin
      bad++;
      $display("FAIL req_ready got=%b want=%b (cyc %0d)", req_ready, er, cyc_n);
    end
    ev = 1'b0;
    if (exp_data.size() > 0) ev = (cyc_n >= exp_cyc[0]);
    total++;
    if (rsp_valid !== ev) begin
      bad++;
      $display("FAIL rsp_valid got=%b want=%b (cyc %0d)", rsp_valid, ev, cyc_n);
    end
    if (ev) begin
      total++;
      if (rsp_rdata !== exp_data[0]) begin
        bad++;
        $display("FAIL rsp_rdata got=%0d want=%0d", rsp_rdata, exp_data[0]);
      end
    end
    if (!run_m) begin
      total++;
      if ({ram_we_n, ram_addr, ram_din} !== {1'b0, AW'(fill_m), INIT}) begin
        bad++;
        $display("FAIL init_write got we_n=%b addr=%0d din=%0d want we_n=0 addr=%0d din=%0d",
                 ram_we_n, ram_addr, ram_din, fill_m, INIT);
      end
    end else begin
      acc = req_valid && er;
      wd  = (acc && req_write) ? req_wdata : '0;
      total++;
      if (acc && ({ram_we_n, ram_addr, ram_din} !== {!req_write, req_addr, wd})) begin
        bad++;
        $display("FAIL ram_issue got we_n=%b addr=%0d din=%0d want we_n=%b addr=%0d din=%0d",
                 ram_we_n, ram_addr, ram_din, !req_write, req_addr, wd);
      end else if (!acc && ({ram_we_n, ram_addr, ram_din} !== {1'b1, AW'(0), DW'(0)})) begin
        bad++;
        $display("FAIL ram_idle got we_n=%b addr=%0d din=%0d want we_n=1 addr=0 din=0",
                 ram_we_n, ram_addr, ram_din);
      end
    end
    pop = ev && rsp_ready;
    wr  = req_write;
    a   = req_addr;
    d   = req_wdata;
    c   = cyc_n;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(exp_data.pop_front());
      void'(exp_cyc.pop_front());
    end
    if (acc) begin
      if (wr) begin
        ref_mem[a] = d;
      end else begin
        exp_data.push_back(ref_mem[a]);
        exp_cyc.push_back(c + 2);
      end
    end
    if (!run_m) begin
      fill_m++;
      if (fill_m == DEPTH) begin
        run_m  = 1'b1;
        fill_m = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
      end
    end else if (clr) begin
      run_m  = 1'b0;
      fill_m = 0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rsp_ready = 1'b0;
    set_idle();
    repeat (2) drive_cycle(acc_b);
    rst = 1'b0;
    repeat (DEPTH) drive_cycle(acc_b);
    total++;
    if ({init_done, req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL reset_run got init_done=%b req_ready=%b want 1 1", init_done, req_ready);
    end
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    set_req(1'b1, 2, 1);
    drive_cycle(acc_b);
    set_req(1'b0, 2, 0);
    drive_cycle(acc_b);
    set_idle();
    drive_cycle(acc_b);
    total++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 2'd1}) begin
      bad++;
      $display("FAIL raw_latency got valid=%b rdata=%0d want valid=1 rdata=1",
               rsp_valid, rsp_rdata);
    end
    drive_cycle(acc_b);
    set_req(1'b0, 3, 0);
    drive_cycle(acc_b);
    set_idle();
    drive_cycle(acc_b);
    total++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, INIT}) begin
      bad++;
      $display("FAIL init_read got valid=%b rdata=%0d want valid=1 rdata=%0d",
               rsp_valid, rsp_rdata, INIT);
    end
    drive_cycle(acc_b);
  endtask

  task automatic test_backpressure();
    bit got;
    rsp_ready = 1'b0;
    set_req(1'b1, 0, 3); drive_cycle(acc_b);
    set_req(1'b1, 1, 1); drive_cycle(acc_b);
    set_req(1'b1, 2, 0); drive_cycle(acc_b);
    set_req(1'b0, 0, 0); drive_cycle(acc_b);
    set_req(1'b0, 1, 0); drive_cycle(acc_b);
    set_req(1'b0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(acc_b);
      total++;
      if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 2'd3}) begin
        bad++;
        $display("FAIL stall got ready=%b valid=%b rdata=%0d want ready=0 valid=1 rdata=3",
                 req_ready, rsp_valid, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;
    drive_cycle(acc_b);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata} !== {1'b1, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL release got ready=%b valid=%b rdata=%0d want ready=1 valid=1 rdata=1",
               req_ready, rsp_valid, rsp_rdata);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      drive_cycle(acc_b);
      got = acc_b;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL third_read got=not accepted want=accepted within 10 cycles");
    end
    set_idle();
    repeat (4) drive_cycle(acc_b);
  endtask

  task automatic test_clr();
    rsp_ready = 1'b1;
    set_req(1'b0, 0, 0);
    drive_cycle(acc_b);
    set_req(1'b0, 1, 0);
    clr = 1'b1;
    drive_cycle(acc_b);
    clr = 1'b0;
    repeat (DEPTH) drive_cycle(acc_b);
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL clr_refill got init_done=%b want 1", init_done);
    end
    set_idle();
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b0, i, 0);
      drive_cycle(acc_b);
      set_idle();
      drive_cycle(acc_b);
      total++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, INIT}) begin
        bad++;
        $display("FAIL clr_readback addr=%0d got valid=%b rdata=%0d want valid=1 rdata=%0d",
                 i, rsp_valid, rsp_rdata, INIT);
      end
      drive_cycle(acc_b);
    end
  endtask

  task automatic test_rst_mid_init();
    rsp_ready = 1'b0;
    set_req(1'b0, 2, 0);
    drive_cycle(acc_b);
    set_idle();
    clr = 1'b1;
    drive_cycle(acc_b);
    clr = 1'b0;
    repeat (2) drive_cycle(acc_b);
    rst = 1'b1;
    drive_cycle(acc_b);
    rst = 1'b0;
    repeat (DEPTH) drive_cycle(acc_b);
    total++;
    if ({rsp_valid, init_done} !== 2'b01) begin
      bad++;
      $display("FAIL rst_mid_init got valid=%b init_done=%b want valid=0 init_done=1",
               rsp_valid, init_done);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = DW'($urandom);
      clr       = ($urandom_range(0, 29) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive_cycle(acc_b);
    end
    set_idle();
    rsp_ready = 1'b1;
    repeat (8) drive_cycle(acc_b);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_clr();
    test_rst_mid_init();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=no finish want=finish by 200000");
    $fatal(1);
  end

endmodule
